framed_parity_checker: RTL and testbench

Parametrised, framed successor to the single-bit Mealy parity checker. It accepts a serial bit stream with a valid qualifier and frames of DATA_BITS data bits plus one parity bit. Each frame is checked against even or odd parity, selected per frame, and a saturating error count is kept. The block sits on the serial receive path and also exposes the running parity as a Mealy output, like its predecessor.

---
 rtl/framed_parity_checker.sv | 134 +++++++++++++
 tb/tb_framed_parity_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/framed_parity_checker.sv
// Framed serial parity checker: DATA_BITS data bits plus one parity bit per frame,
// per-frame even/odd selection, saturating error counter and a Mealy running-parity output.
module framed_parity_checker #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             sof,
  input  logic             odd_mode,
  input  logic             clr_cnt,
  output logic             state,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             abort,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 err_inc;
  logic                 flag;

  // Next-state, frame bookkeeping and result registers
  always_comb begin
    fsm_d     = fsm_q;
    bit_cnt_d = bit_cnt_q;
    state_d   = state_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    err_d     = err_q;
    abort_d   = 1'b0;
    err_inc   = 1'b0;
    err_cnt_d = err_cnt_q;
    // Parity error: total parity differs from the expected value (0 even, 1 odd)
    flag      = state_q ^ in ^ mode_q;

    if (in_valid) begin
      if (sof) begin
        abort_d   = (fsm_q != IDLE);
        state_d   = in;
        bit_cnt_d = BIT_CNT_W'(1);
        mode_d    = odd_mode;
        fsm_d     = (DATA_BITS == 1) ? PARITY : DATA;
      end else begin
        case (fsm_q)
          DATA: begin
            state_d   = state_q ^ in;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) fsm_d = PARITY;
          end
          PARITY: begin
            done_d    = 1'b1;
            err_d     = flag;
            err_inc   = flag;
            state_d   = 1'b0;
            bit_cnt_d = '0;
            fsm_d     = IDLE;
          end
          default: ;
        endcase
      end
    end

    busy_d = (fsm_d != IDLE);

    // Clear dominates a coincident increment; increment saturates at all-ones
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= IDLE;
      bit_cnt_q <= '0;
      state_q   <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Mealy running parity; forced low while reset is asserted
  always_comb begin
    out = 1'b0;
    if (rst) begin
      if (fsm_q == IDLE) out = in & in_valid & sof;
      else               out = state_q ^ (in & in_valid);
    end
  end

  assign state   = state_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign abort   = abort_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_framed_parity_checker.sv
// Bench for framed_parity_checker: frame table, corner sequences and random stimulus
// checked against a queue-based frame model.
module tb_framed_parity_checker;

  localparam int unsigned DB = 8;
  localparam int unsigned CW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk, rst;
  logic          in_r, valid_r, sof_r, odd_r, clr_r;
  logic          state, out, busy, done, err, abort;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int abort_seen = 0;

  framed_parity_checker #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in(in_r), .in_valid(valid_r), .sof(sof_r),
    .odd_mode(odd_r), .clr_cnt(clr_r), .state(state), .out(out), .busy(busy),
    .done(done), .err(err), .abort(abort), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: the bits received so far in the current frame
  logic q_bits[$];
  logic m_in_frame, m_mode, m_done, m_err, m_abort;
  int   m_cnt;

  function automatic logic q_par();
    logic p = 1'b0;
    foreach (q_bits[i]) p ^= q_bits[i];
    return p;
  endfunction

  function automatic void m_reset();
    q_bits.delete();
    m_in_frame = 1'b0; m_mode = 1'b0; m_done = 1'b0;
    m_err = 1'b0; m_abort = 1'b0; m_cnt = 0;
  endfunction

  function automatic logic m_out(logic i, logic v, logic s);
    if (!m_in_frame) return i & v & s;
    return q_par() ^ (i & v);
  endfunction

  function automatic void m_update(logic i, logic v, logic s, logic o, logic c);
    logic expected;
    m_done = 1'b0;
    m_abort = 1'b0;
    if (v) begin
      if (s) begin
        m_abort = m_in_frame;
        q_bits.delete();
        q_bits.push_back(i);
        m_mode = o;
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        if (q_bits.size() < DB) begin
          q_bits.push_back(i);
        end else begin
          expected = m_mode ? 1'b1 : 1'b0;
          m_done = 1'b1;
          m_err = ((q_par() ^ i) != expected);
          if (m_err && m_cnt < CNT_MAX) m_cnt++;
          m_in_frame = 1'b0;
          q_bits.delete();
        end
      end
    end
    if (c) m_cnt = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_regs();
    chk("state", 32'(state), 32'(m_in_frame ? q_par() : 1'b0));
    chk("busy", 32'(busy), 32'(m_in_frame));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("abort", 32'(abort), 32'(m_abort));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  // One clock: drive, check Mealy out, clock, check registered outputs
  task automatic step(input logic i, input logic v, input logic s, input logic o, input logic c);
    in_r = i; valid_r = v; sof_r = s; odd_r = o; clr_r = c;
    #1;
    chk("out", 32'(out), 32'(m_out(i, v, s)));
    m_update(i, v, s, o, c);
    @(posedge clk);
    #1;
    if (done) done_seen++;
    if (abort) abort_seen++;
    chk_regs();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic o,
                            input int gap, input logic clr_par);
    for (int i = 0; i < 8; i++) begin
      step(d[i], 1'b1, (i == 0), o, 1'b0);
      repeat (gap) step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
    step(p, 1'b1, 1'b0, o, clr_par);
  endtask

  typedef struct {
    logic [7:0]    data;
    logic          par;
    logic          odd;
    int            gap;
    logic          exp_err;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];
  logic [CW-1:0] sat_exp[5];
  logic [7:0] a5;
  int d0, a0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 0, 1'b0, 2'd0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 0, 1'b1, 2'd1};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 0, 1'b0, 2'd1};
    vecs[3] = '{8'h03, 1'b0, 1'b1, 0, 1'b1, 2'd2};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 2, 1'b0, 2'd2};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 0, 1'b1, 2'd3};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 0, 1'b0, 2'd3};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 1, 1'b1, 2'd3};
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    a5 = 8'hA5;

    rst = 1'b0; in_r = 1'b0; valid_r = 1'b0; sof_r = 1'b0; odd_r = 1'b0; clr_r = 1'b0;
    m_reset();

    // Reset held with active inputs: every output stays low
    for (int k = 0; k < 3; k++) begin
      in_r = 1'(k); valid_r = 1'b1; sof_r = 1'b1; clr_r = 1'b0;
      #2;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    // Reset mid-frame after four data bits
    for (int i = 0; i < 4; i++) step(a5[i], 1'b1, (i == 0), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    m_reset();
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_discard_busy", 32'(busy), 32'd0);

    // Table of whole frames with hand-derived results
    for (int n = 0; n < 8; n++) begin
      send_frame(vecs[n].data, vecs[n].par, vecs[n].odd, vecs[n].gap, 1'b0);
      chk("tbl_done", 32'(done), 32'd1);
      chk("tbl_err", 32'(err), 32'(vecs[n].exp_err));
      chk("tbl_cnt", 32'(err_cnt), 32'(vecs[n].exp_cnt));
    end

    // Clear, then saturation with back-to-back bad frames
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0, 1'b0, 0, 1'b0);
      chk("sat_cnt", 32'(err_cnt), 32'(sat_exp[k]));
    end
    send_frame(8'h01, 1'b0, 1'b0, 0, 1'b1);
    chk("clr_wins_cnt", 32'(err_cnt), 32'd0);
    chk("clr_wins_err", 32'(err), 32'd1);

    // Restart at data bit 5, then a good frame
    d0 = done_seen;
    a0 = abort_seen;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk("restart_aborts", 32'(abort_seen - a0), 32'd1);
    chk("restart_dones", 32'(done_seen - d0), 32'd1);
    chk("restart_err", 32'(err), 32'd0);

    // Random traffic against the frame model
    repeat (4000) begin
      step(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
           1'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
